// File: rtl/axi_mm_axis_reader.sv
// axi_mm_axis_reader
// Memory-to-stream read engine. A (byte address, byte length) command is
// turned into a series of single-beat AXI4 reads, one outstanding at a time,
// and the returned data leaves as one AXI-Stream frame with per-beat tkeep
// and tlast on the final beat. A one-entry output register holds each beat
// under stream backpressure before the next read address is issued.
//
// Optional feature: define AXI_MM_AXIS_READER_TUSER_EN to add m_axis_tuser,
// which flags each beat whose read response was not OKAY. Without the macro
// errors are only visible through status_error.

`timescale 1ns/1ps

module axi_mm_axis_reader #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 6,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    // command / status
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  status_valid,
    output logic                  status_error,

    // AXI4 read address channel
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI4 read data channel
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    // AXI-Stream output
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
`ifdef AXI_MM_AXIS_READER_TUSER_EN
    ,
    output logic                  m_axis_tuser
`endif
);

    // Byte offset bits within one beat.
    localparam int OFF = $clog2(KEEP_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        OUT
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [KEEP_WIDTH-1:0] last_keep;
    logic                  err;

    // Keep mask of the final beat: low (len mod KEEP_WIDTH) lanes, or all
    // lanes when the length is an exact multiple of the beat size.
    function automatic logic [KEEP_WIDTH-1:0] tail_keep(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0]  rem;
        logic [KEEP_WIDTH-1:0] mask;
        rem = len & LEN_WIDTH'(KEEP_WIDTH - 1);
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            mask[i] = (rem == '0) || (i < int'(rem));
        end
        return mask;
    endfunction

    // Number of beats covering len bytes from an aligned start: ceil(len / KEEP_WIDTH).
    function automatic logic [LEN_WIDTH-1:0] beat_count(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, len} + (LEN_WIDTH + 1)'(KEEP_WIDTH - 1);
        return LEN_WIDTH'(sum >> OFF);
    endfunction

    // Start address with the sub-beat byte offset dropped.
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(KEEP_WIDTH - 1);
    endfunction

    // Fixed AXI attributes: single-beat INCR reads of the full bus width.
    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(OFF);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;

    // Read ID and rlast carry no information for single-beat reads.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, m_axi_rlast};

    // Command sequencer: one address/data/stream round trip per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            status_valid  <= 1'b0;
            status_error  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            beats_left    <= '0;
            last_keep     <= '0;
            err           <= 1'b0;
`ifdef AXI_MM_AXIS_READER_TUSER_EN
            m_axis_tuser  <= 1'b0;
`endif
        end else begin
            // Status is a single-cycle pulse unless re-armed below.
            status_valid <= 1'b0;
            status_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        m_axi_araddr <= align_addr(cmd_addr);
                        beats_left   <= beat_count(cmd_len);
                        last_keep    <= tail_keep(cmd_len);
                        err          <= 1'b0;
                        if (cmd_len == '0) begin
                            // Empty transfer: report completion, touch nothing else.
                            status_valid <= 1'b1;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= AR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= R;
                    end
                end

                R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready  <= 1'b0;
                        m_axis_tdata  <= m_axi_rdata;
                        m_axis_tkeep  <= (beats_left == LEN_WIDTH'(1)) ? last_keep : '1;
                        m_axis_tlast  <= (beats_left == LEN_WIDTH'(1));
                        m_axis_tvalid <= 1'b1;
                        err           <= err | (m_axi_rresp != 2'b00);
`ifdef AXI_MM_AXIS_READER_TUSER_EN
                        m_axis_tuser  <= (m_axi_rresp != 2'b00);
`endif
                        state         <= OUT;
                    end
                end

                OUT: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        if (m_axis_tlast) begin
                            status_valid <= 1'b1;
                            status_error <= err;
                            cmd_ready    <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            // Address wraps naturally at 2^ADDR_WIDTH.
                            m_axi_araddr  <= m_axi_araddr + ADDR_WIDTH'(KEEP_WIDTH);
                            m_axi_arvalid <= 1'b1;
                            beats_left    <= beats_left - LEN_WIDTH'(1);
                            state         <= AR;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_mm_axis_reader.md
# axi_mm_axis_reader

Memory-to-stream read engine: accepts a (byte address, byte length) command, issues single-beat AXI4 reads over the region, and emits the returned data as one AXI-Stream frame with per-beat tkeep and tlast on the final beat. It is the read-side counterpart of the application's stream-to-memory write bridge and sits between the application's command logic and the AXI memory port. One read is outstanding at a time; a one-entry output register holds data under stream backpressure.

## Interface
- DATA_WIDTH, 512, AXI and stream data width in bits (power of two, ≥ 8)
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat
- ADDR_WIDTH, 34, AXI address width
- ID_WIDTH, 6, AXI ID width
- LEN_WIDTH, 16, width of the command byte length

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(KEEP_WIDTH) bits ignored and treated as 0
- cmd_len  in  LEN_WIDTH  transfer length in bytes
- cmd_valid / cmd_ready  in / out  1  command handshake
- status_valid  out  1  one-cycle pulse when a command completes
- status_error  out  1  valid with status_valid; 1 if any beat returned rresp ≠ 0
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  beat address
- m_axi_arlen  out  8  constant 0
- m_axi_arsize  out  3  constant log2(KEEP_WIDTH)
- m_axi_arburst  out  2  constant 1 (INCR)
- m_axi_arlock / arcache / arprot  out  1/4/3  constant 0
- m_axi_arvalid / m_axi_arready  out / in  1  read address handshake
- m_axi_rid  in  ID_WIDTH  ignored
- m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rlast  in  1 (ignored)
- m_axi_rvalid / m_axi_rready  in / out  1  read data handshake
- m_axis_tdata  out  DATA_WIDTH;  m_axis_tkeep  out  KEEP_WIDTH;  m_axis_tlast  out  1
- m_axis_tvalid / m_axis_tready  out / in  1  stream handshake

## Operation
- States: IDLE, AR, R, OUT.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch aligned address, beats = ceil(cmd_len/KEEP_WIDTH), last_bytes = cmd_len mod KEEP_WIDTH (0 → KEEP_WIDTH), clear error flag. If cmd_len=0: stay IDLE, pulse status (error=0) next cycle, no AXI or stream activity. Otherwise → AR.
- AR: arvalid=1, araddr=current address, held stable until arready. On handshake → R.
- R: rready=1. On rvalid: capture rdata into output register, OR (rresp≠0) into error flag, → OUT.
- OUT: tvalid=1; tdata/tkeep/tlast stable until tready. tkeep all ones except final beat: low last_bytes bits set. tlast=1 only on final beat. On handshake: final beat → IDLE with status pulse; else address += KEEP_WIDTH (modulo 2^ADDR_WIDTH), remaining beats −1, → AR.
- Erroring beats are still forwarded; command is never aborted.
- No 4 KiB or address-range checking; caller's responsibility.

## Timing
- All outputs registered. Reset values: cmd_ready=0, arvalid=0, rready=0, tvalid=0, tlast=0, status_valid=0, status_error=0; araddr/tdata/tkeep don't-care-but-stable (reset to 0).
- cmd_ready rises the first cycle after rst deasserts.
- Cmd handshake at cycle N → arvalid=1 at N+1. arready at cycle A → arvalid=0, rready=1 at A+1. rvalid at cycle D → rready=0, tvalid=1 at D+1. tready at cycle K → tvalid=0 at K+1, plus arvalid=1 (next beat) or cmd_ready=1 and status_valid=1 (final beat).
- Minimum 4 cycles per beat with zero-wait slaves.
- cmd_ready is 0 in AR/R/OUT and in the status-pulse cycle for length-0 commands.
- rst asserted in any state: next cycle all outputs at reset values, state IDLE, in-flight AXI transaction abandoned (interconnect reset together), no status pulse.

## Configuration
- AXI_MM_AXIS_READER_TUSER_EN defined: adds port m_axis_tuser (out, 1), registered with tdata, = 1 when that beat's rresp ≠ 0, reset 0.
- Not defined: port absent; errors reported only via status_error.

## Test plan
- Reset: hold rst 3 cycles, arvalid high pre-reset → all outputs 0 one cycle after rst edge; cmd_ready=1 first cycle after release.
- cmd_addr=0x1000, cmd_len=64 → one AR at 0x1000, one beat tkeep=all ones, tlast=1, status_valid pulse, status_error=0.
- cmd_addr=0x1010, cmd_len=130 → ARs at 0x1000, 0x1040, 0x1080; 3 beats, last tkeep=0x3 with tlast=1, earlier beats tlast=0.
- Same as above with tready low 5 cycles on beat 2 and arready delayed 3 cycles → tdata/tkeep stable while stalled, no AR issued during stall, araddr stable while waiting on arready, output frame identical.
- cmd_len=130, rresp=2 on beat 2 → all 3 beats delivered, status_error=1; with TUSER_EN, tuser=0,1,0.
- cmd_len=0 → no arvalid, no tvalid, status_valid pulse next cycle with error=0; rst asserted during beat 2's R state → clean IDLE, following 64-byte command completes normally.
